// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state and selects the 11-bit frame.
package uart_pkg;

  localparam int FRAME_BITS_PLAIN  = 10;
  localparam int FRAME_BITS_PARITY = 11;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  localparam int FRAME_BITS = FRAME_BITS_PLAIN;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_t;
`endif

  function automatic int bit_interval(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..BIT_INTERVAL-1 and pulses tick on the last count.
// clear restarts the period so a new frame always begins on a full bit.
module uart_baud_gen #(
  parameter int BIT_INTERVAL = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_INTERVAL > 1) ? $clog2(BIT_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_INTERVAL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx
  import uart_pkg::*;
#(
  parameter int W5Frequency = 6_250_000,
  parameter int baudRate    = 230400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic       TxReady,
  output logic       TxD,
  output logic       busy,
  output logic       txDone,
  output tx_state_t  fsm_state
);

  localparam int bitInterval = bit_interval(W5Frequency, baudRate);

  // Handshake: TxStart is the valid, TxReady the ready; a byte transfers on
  // any cycle where both are high, TxData is only sampled then, and TxStart
  // with TxReady low is simply ignored (the held byte is never overwritten).

  tx_state_t  state, next_state;
  logic [2:0] bit_idx, next_idx;
  logic [7:0] hold_q, shift_q;
  logic       hold_full;
  logic       txd_q, txd_d;
  logic       load, tick, accept;

  assign accept = TxStart && !hold_full;

  uart_baud_gen #(
    .BIT_INTERVAL(bitInterval)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(load),
    .tick (tick)
  );

  always_comb begin
    next_state = state;
    next_idx   = bit_idx;
    load       = 1'b0;
    txd_d      = 1'b1;
    case (state)
      IDLE: begin
        if (hold_full) begin
          next_state = START;
          load       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          next_state = DATA;
          next_idx   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
            next_idx   = 3'd0;
          end else begin
            next_idx = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) next_state = STOP;
      end
`endif
      STOP: begin
        // A byte already waiting goes straight out with no idle gap.
        if (tick) begin
          if (hold_full) begin
            next_state = START;
            load       = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase

    // The line register follows the state being entered, so TxD and state stay aligned.
    case (next_state)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[next_idx];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = ^shift_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= 3'd0;
      hold_q    <= 8'd0;
      hold_full <= 1'b0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
    end else begin
      state   <= next_state;
      bit_idx <= next_idx;
      txd_q   <= txd_d;
      if (load) begin
        shift_q   <= hold_q;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold_q    <= TxData;
        hold_full <= 1'b1;
      end
    end
  end

  assign TxReady   = !hold_full;
  assign TxD       = txd_q;
  assign busy      = (state != IDLE);
  assign txDone    = (state == STOP) && tick;
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line monitor decodes frames against a queue
// of bytes pushed at acceptance and checks bit timing, framing and txDone.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BIT = 6_250_000 / 230400;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FRAME_CYC = FRAME * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       TxStart = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       TxReady, TxD, busy, txDone;
  tx_state_t  fsm_state;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  logic [7:0] exp_q[$];
  int start_log[$];
  int end_log[$];

  uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .TxData   (TxData),
    .TxStart  (TxStart),
    .TxReady  (TxReady),
    .TxD      (TxD),
    .busy     (busy),
    .txDone   (txDone),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    while (TxReady !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check("ready_wait", TxReady, 1'b1);
    TxStart = 1'b1;
    TxData  = b;
    acc     = cycle_cnt;
    exp_q.push_back(b);
    step();
    TxStart = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (end_log.size() < n && t < 5000) begin
      step();
      t++;
    end
    check("frame_timeout", end_log.size() >= n, 1'b1);
  endtask

  task automatic wait_start(input int n);
    int t;
    t = 0;
    while (start_log.size() < n && t < 5000) begin
      step();
      t++;
    end
    check("start_timeout", start_log.size() >= n, 1'b1);
  endtask

  // Line monitor: samples on the falling edge, one check per bit period.
  initial begin : monitor
    logic        in_frame;
    int          bit_no, cyc, bad, done_cnt, busy_cnt;
    logic [10:0] bits;
    logic [7:0]  cur, decoded;
    in_frame = 1'b0;
    bit_no = 0; cyc = 0; bad = 0; done_cnt = 0; busy_cnt = 0;
    bits = '1; cur = 8'h00; decoded = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && TxD === 1'b0) begin
          check("frame_expected", exp_q.size() > 0, 1'b1);
          cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = cur[i];
`ifdef UART_TX_PARITY_EN
          bits[9] = ^cur;
`endif
          in_frame = 1'b1;
          bit_no = 0; cyc = 0; bad = 0; done_cnt = 0; busy_cnt = 0;
          decoded = 8'h00;
          start_log.push_back(cycle_cnt);
        end
        if (in_frame) begin
          if (TxD !== bits[bit_no]) bad++;
          if (busy === 1'b1) busy_cnt++;
          if (txDone === 1'b1) begin
            done_cnt++;
            if (!(bit_no == FRAME - 1 && cyc == BIT - 1)) bad++;
          end
          if (cyc == BIT / 2 && bit_no >= 1 && bit_no <= 8) decoded[bit_no-1] = TxD;
          cyc++;
          if (cyc == BIT) begin
            check($sformatf("bit%0d", bit_no), bad, 0);
            bad = 0;
            cyc = 0;
            bit_no++;
            if (bit_no == FRAME) begin
              check("byte", decoded, cur);
              check("done_cnt", done_cnt, 1);
              check("frame_len", busy_cnt, FRAME_CYC);
              end_log.push_back(cycle_cnt);
              in_frame = 1'b0;
            end
          end
        end else if (txDone !== 1'b0 || busy !== 1'b0) begin
          check("idle_outputs", {txDone, busy}, 2'b00);
        end
      end
    end
  end

  initial begin : stimulus
    int acc, acc2, s, cnt, n, idle_bad, ns, ne;

    // Reset values
    repeat (3) step();
    check("rst_txd", TxD, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", TxReady, 1'b1);
    check("rst_done", txDone, 1'b0);
    check("rst_state", fsm_state, IDLE);
    reset = 1'b0;
    step();

    // Single frames from idle, start bit two cycles after acceptance
    send(8'h55, acc);
    wait_frames(1);
    check("latency_55", start_log[0] - acc, 2);
    check("idle_after_55", TxD, 1'b1);

    send(8'h07, acc);
    wait_frames(2);
    check("latency_07", start_log[1] - acc, 2);

    // Back-to-back: second start bit directly follows the first stop bit
    send(8'hA5, acc);
    send(8'h3C, acc2);
    wait_frames(4);
    check("b2b_gap", start_log[3], end_log[2] + 1);

    // TxStart held high with changing data: only accepted bytes go out
    cnt = 0;
    n = 0;
    while (cnt < 3 && n < 3000) begin
      TxData  = 8'($urandom_range(0, 255));
      TxStart = 1'b1;
      if (TxReady === 1'b1) begin
        exp_q.push_back(TxData);
        cnt++;
      end
      step();
      n++;
    end
    TxStart = 1'b0;
    check("held_accepts", cnt, 3);
    wait_frames(7);

    // Acceptance on the stop-bit terminal count of an idle-bound frame
    send(8'h81, acc);
    wait_start(8);
    s = start_log[7];
    while (cycle_cnt < s + FRAME_CYC - 1) step();
    check("tc_ready", TxReady, 1'b1);
    check("tc_done", txDone, 1'b1);
    TxStart = 1'b1;
    TxData  = 8'hFF;
    acc     = cycle_cnt;
    exp_q.push_back(8'hFF);
    step();
    TxStart = 1'b0;
    wait_frames(9);
    check("tc_latency", start_log[8] - acc, 2);

    // One-cycle reset at cycle 100 of a frame with a second byte held
    send(8'h5A, acc);
    wait_start(10);
    s = start_log[9];
    send(8'hC3, acc2);
    while (cycle_cnt < s + 100) step();
    check("held_before_reset", TxReady, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    step();
    check("mid_rst_txd", TxD, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", TxReady, 1'b1);
    check("mid_rst_done", txDone, 1'b0);
    check("mid_rst_state", fsm_state, IDLE);
    reset = 1'b0;
    ns = start_log.size();
    ne = end_log.size();
    idle_bad = 0;
    repeat (400) begin
      step();
      if (TxD !== 1'b1 || busy !== 1'b0 || txDone !== 1'b0) idle_bad++;
    end
    check("idle_after_reset", idle_bad, 0);
    check("no_start_after_reset", start_log.size(), ns);
    check("no_end_after_reset", end_log.size(), ne);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
